// File: rtl/cgra_pwr_seq_if.sv
// Power-gate handshake between the X-HEEP side (master) and the CGRA power sequencer (slave).
interface cgra_pwr_seq_if;
  logic       sw_off_req_i;
  logic       iso_req_i;
  logic       sw_ack_o;
  logic       iso_o;
  logic       sub_rst_no;
  logic       sub_clk_en_o;
  logic       busy_o;
  logic [2:0] state_o;

  modport master (
    output sw_off_req_i, iso_req_i,
    input  sw_ack_o, iso_o, sub_rst_no, sub_clk_en_o, busy_o, state_o
  );

  modport slave (
    input  sw_off_req_i, iso_req_i,
    output sw_ack_o, iso_o, sub_rst_no, sub_clk_en_o, busy_o, state_o
  );
endinterface

// File: rtl/cgra_pwr_seq.sv
// CGRA power sequencer: orders switch settle, clock enable, reset release and isolation
// release on power-up (reverse on power-down); forces OFF whenever the clock wizard loses lock.
module cgra_pwr_seq #(
  parameter int SWITCH_WAIT = 16,
  parameter int RST_HOLD    = 8,
  parameter int ISO_SETUP   = 4,
  parameter int CNT_W       = 8
) (
  input  logic           clk_gen,
  input  logic           rst_n,
  input  logic           locked_i,
  cgra_pwr_seq_if.slave  pwr
);

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    UP_SW  = 3'd1,
    UP_CLK = 3'd2,
    UP_ISO = 3'd3,
    ON     = 3'd4,
    DN_ISO = 3'd5,
    DN_RST = 3'd6,
    DN_SW  = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] SW_LOAD  = CNT_W'(SWITCH_WAIT - 1);
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] ISO_LOAD = CNT_W'(ISO_SETUP - 1);

  logic [1:0]       lk_sync_reg;
  logic             lk;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             cnt_zero;
  logic             iso_reg, iso_next;
  logic             sub_rst_n_reg, sub_rst_n_next;
  logic             clk_en_reg, clk_en_next;
  logic             busy_reg, busy_next;
  logic             ack_reg, ack_next;

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) lk_sync_reg <= 2'b00;
    else        lk_sync_reg <= {lk_sync_reg[0], locked_i};
  end

  assign lk       = lk_sync_reg[1];
  assign cnt_zero = (cnt_reg == '0);

  // Requests are only honoured in OFF/ON; a running sequence always completes unless lock drops.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (!lk) begin
      state_next = OFF;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        OFF: if (!pwr.sw_off_req_i) begin
          state_next = UP_SW;
          cnt_next   = SW_LOAD;
        end
        UP_SW: if (cnt_zero) begin
          state_next = UP_CLK;
          cnt_next   = RST_LOAD;
        end else cnt_next = cnt_reg - CNT_W'(1);
        UP_CLK: if (cnt_zero) begin
          state_next = UP_ISO;
          cnt_next   = ISO_LOAD;
        end else cnt_next = cnt_reg - CNT_W'(1);
        UP_ISO: if (cnt_zero) state_next = ON;
                else cnt_next = cnt_reg - CNT_W'(1);
        ON: if (pwr.sw_off_req_i) begin
          state_next = DN_ISO;
          cnt_next   = ISO_LOAD;
        end
        DN_ISO: if (cnt_zero) state_next = DN_RST;
                else cnt_next = cnt_reg - CNT_W'(1);
        DN_RST: begin
          state_next = DN_SW;
          cnt_next   = SW_LOAD;
        end
        DN_SW: if (cnt_zero) state_next = OFF;
               else cnt_next = cnt_reg - CNT_W'(1);
        default: begin
          state_next = OFF;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge as state_o.
  always_comb begin
    iso_next       = !((state_next == ON) && !pwr.iso_req_i);
    sub_rst_n_next = state_next inside {UP_ISO, ON, DN_ISO};
    clk_en_next    = state_next inside {UP_CLK, UP_ISO, ON, DN_ISO};
    busy_next      = !(state_next inside {OFF, ON});
    ack_next       = ((state_next == ON)  && !pwr.sw_off_req_i) ||
                     ((state_next == OFF) &&  pwr.sw_off_req_i);
  end

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= OFF;
      cnt_reg       <= '0;
      iso_reg       <= 1'b1;
      sub_rst_n_reg <= 1'b0;
      clk_en_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      ack_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      iso_reg       <= iso_next;
      sub_rst_n_reg <= sub_rst_n_next;
      clk_en_reg    <= clk_en_next;
      busy_reg      <= busy_next;
      ack_reg       <= ack_next;
    end
  end

  assign pwr.state_o      = state_reg;
  assign pwr.iso_o        = iso_reg;
  assign pwr.sub_rst_no   = sub_rst_n_reg;
  assign pwr.sub_clk_en_o = clk_en_reg;
  assign pwr.busy_o       = busy_reg;
  assign pwr.sw_ack_o     = ack_reg;

  a_rst_needs_clk: assert property (@(posedge clk_gen) disable iff (!rst_n)
    sub_rst_n_reg |-> clk_en_reg);
  a_deiso_only_on: assert property (@(posedge clk_gen) disable iff (!rst_n)
    !iso_reg |-> (state_reg == ON));

endmodule

// File: tb/tb_cgra_pwr_seq.sv
// Directed bench for cgra_pwr_seq: default-parameter instance plus a 1/1/1 fast instance.
module tb_cgra_pwr_seq;
  logic clk_gen = 1'b0;
  logic rst_n;
  logic locked_i;
  int   n_tests = 0;
  int   n_fail  = 0;

  cgra_pwr_seq_if d_if();
  cgra_pwr_seq_if f_if();

  cgra_pwr_seq dut (
    .clk_gen  (clk_gen),
    .rst_n    (rst_n),
    .locked_i (locked_i),
    .pwr      (d_if)
  );

  cgra_pwr_seq #(.SWITCH_WAIT(1), .RST_HOLD(1), .ISO_SETUP(1), .CNT_W(8)) dut_fast (
    .clk_gen  (clk_gen),
    .rst_n    (rst_n),
    .locked_i (locked_i),
    .pwr      (f_if)
  );

  always #5 clk_gen = ~clk_gen;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_gen);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0h", tag, got);
    end
  endtask

  // state, iso, sub_rst_n, clk_en, busy, ack of the default instance
  task automatic check_d(input string tag, input logic [2:0] st, input logic iso,
                         input logic rn, input logic ce, input logic bsy, input logic ack);
    check({tag, ".state"},  32'(d_if.state_o),      32'(st));
    check({tag, ".iso"},    32'(d_if.iso_o),        32'(iso));
    check({tag, ".rst_n"},  32'(d_if.sub_rst_no),   32'(rn));
    check({tag, ".clk_en"}, 32'(d_if.sub_clk_en_o), 32'(ce));
    check({tag, ".busy"},   32'(d_if.busy_o),       32'(bsy));
    check({tag, ".ack"},    32'(d_if.sw_ack_o),     32'(ack));
  endtask

  initial begin
    rst_n = 1'b0;
    locked_i = 1'b1;
    d_if.sw_off_req_i = 1'b0;
    d_if.iso_req_i    = 1'b0;
    f_if.sw_off_req_i = 1'b1;
    f_if.iso_req_i    = 1'b0;
    tick(2);
    check_d("reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Cold boot: lk rises after two edges, OFF->UP_SW on the third
    rst_n = 1'b1;
    tick(2);
    check("boot.lk_latency", 32'(d_if.state_o), 32'd0);
    check("fast.off_ack", 32'(f_if.sw_ack_o), 32'd1);
    tick(1);
    check_d("boot.up_sw", 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(15);
    check_d("boot.up_sw_end", 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);
    check_d("boot.up_clk", 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(8);
    check_d("boot.up_iso", 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    d_if.iso_req_i = 1'b1;
    tick(1);
    check("up_iso.iso_req_ignored", 32'(d_if.iso_o), 32'd1);
    tick(3);
    check_d("boot.on_isoreq", 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    d_if.iso_req_i = 1'b0;
    tick(1);
    check("on.iso_req0", 32'(d_if.iso_o), 32'd0);
    d_if.iso_req_i = 1'b1;
    tick(1);
    check("on.iso_req1", 32'(d_if.iso_o), 32'd1);
    d_if.iso_req_i = 1'b0;
    tick(1);
    check("on.iso_req0b", 32'(d_if.iso_o), 32'd0);

    // Power-down: 22 edges from sampling to OFF with ack
    d_if.sw_off_req_i = 1'b1;
    tick(1);
    check_d("dn.iso", 3'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(4);
    check_d("dn.rst", 3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);
    check("dn.sw", 32'(d_if.state_o), 32'd7);
    tick(15);
    check("dn.sw_end", 32'(d_if.state_o), 32'd7);
    tick(1);
    check_d("dn.off", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Power up again (29 edges), then reverse the request during DN_SW
    d_if.sw_off_req_i = 1'b0;
    tick(1);
    check("re.up_sw", 32'(d_if.state_o), 32'd1);
    tick(28);
    check_d("re.on", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    d_if.sw_off_req_i = 1'b1;
    tick(6);
    check("rev.dn_sw", 32'(d_if.state_o), 32'd7);
    d_if.sw_off_req_i = 1'b0;
    tick(15);
    check_d("rev.dn_sw_hold", 3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);
    check_d("rev.off_no_ack", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    check_d("rev.up_sw", 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Lock loss in UP_CLK
    tick(16);
    check("ll.up_clk", 32'(d_if.state_o), 32'd2);
    locked_i = 1'b0;
    tick(2);
    check("ll.sync_delay", 32'(d_if.state_o), 32'd2);
    tick(1);
    check_d("ll.off", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    locked_i = 1'b1;
    tick(3);
    check("relock.up_sw", 32'(d_if.state_o), 32'd1);
    tick(28);
    check_d("relock.on", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

    // Lock loss in ON coinciding with an off request: lock loss wins
    locked_i = 1'b0;
    tick(2);
    check("ll_on.still_on", 32'(d_if.state_o), 32'd4);
    d_if.sw_off_req_i = 1'b1;
    tick(1);
    check_d("ll_on.off", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    locked_i = 1'b1;
    tick(4);
    check("relock_req_off.stays", 32'(d_if.state_o), 32'd0);

    // Async reset in the middle of UP_ISO
    d_if.sw_off_req_i = 1'b0;
    tick(25);
    check("ar.up_iso", 32'(d_if.state_o), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_d("ar.async", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Fast instance: 3 edges from UP_SW entry to ON, 4 from off-request to OFF
    d_if.sw_off_req_i = 1'b1;
    tick(2);
    f_if.sw_off_req_i = 1'b0;
    tick(1);
    check("fast.up_sw", 32'(f_if.state_o), 32'd1);
    tick(1);
    check("fast.up_clk", 32'(f_if.state_o), 32'd2);
    tick(1);
    check("fast.up_iso", 32'(f_if.state_o), 32'd3);
    tick(1);
    check("fast.on", 32'(f_if.state_o), 32'd4);
    check("fast.on_iso", 32'(f_if.iso_o), 32'd0);
    check("fast.on_ack", 32'(f_if.sw_ack_o), 32'd1);
    f_if.sw_off_req_i = 1'b1;
    tick(1);
    check("fast.dn_iso", 32'(f_if.state_o), 32'd5);
    tick(1);
    check("fast.dn_rst", 32'(f_if.state_o), 32'd6);
    tick(1);
    check("fast.dn_sw", 32'(f_if.state_o), 32'd7);
    tick(1);
    check("fast.off", 32'(f_if.state_o), 32'd0);
    check("fast.off_ack2", 32'(f_if.sw_ack_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
